// File: rtl/event_capture_queue.sv
// rtl/event_capture_queue.sv - edge-detecting event capture into a show-ahead queue with an overflow counter
module event_capture_queue #(
  parameter int NUM_CH    = 8,
  parameter int DEPTH     = 32,
  parameter int TS_WIDTH  = 16,
  parameter int OVF_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in,
  input  logic [NUM_CH-1:0]            rise_en,
  input  logic [NUM_CH-1:0]            fall_en,
  input  logic                         rd_en,
  output logic [TS_WIDTH+NUM_CH-1:0]   dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count,
  output logic [OVF_WIDTH-1:0]         ovf_count,
  input  logic                         ovf_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_WIDTH + NUM_CH;

  logic [NUM_CH-1:0]    in_q;
  logic [NUM_CH-1:0]    in_qq;
  logic [NUM_CH-1:0]    ev;
  logic [TS_WIDTH-1:0]  ts;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          cnt;
  logic [OVF_WIDTH-1:0] ovf;
  logic [EW-1:0]        mem [DEPTH];
  logic                 do_wr;
  logic                 do_rd;
  logic                 drop;

  assign ev    = (in_q & ~in_qq & rise_en) | (~in_q & in_qq & fall_en);
  assign empty = (cnt == '0);
  // DEPTH is a power of two, so the occupancy MSB alone marks a full queue
  assign full  = cnt[AW];
  assign do_rd = rd_en && !empty;
  assign do_wr = (|ev) && (!full || do_rd);
  assign drop  = (|ev) && !do_wr;

  assign count     = cnt;
  assign ovf_count = ovf;
  assign dout      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // both stages load the live level so a line already high causes no edge
      in_q   <= in;
      in_qq  <= in;
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
    end else begin
      in_q   <= in;
      in_qq  <= in_q;
      ts     <= ts + 1'b1;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      if (ovf_clear)
        ovf <= '0;
      else if (drop && (ovf != '1))
        ovf <= ovf + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr)
      mem[wr_ptr] <= {ts, ev};
  end

endmodule

// File: tb/tb_event_capture_queue.sv
// tb/tb_event_capture_queue.sv - scoreboard bench for event_capture_queue (default and narrow-width instances)
module tb_event_capture_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_v, s_in, rise_en, fall_en;
  logic        rd_en, s_rd_en, ovf_clear, s_ovf_clear;
  logic [23:0] dout;
  logic        empty, full;
  logic [5:0]  count;
  logic [7:0]  ovf_count;
  logic [11:0] s_dout;
  logic        s_empty, s_full;
  logic [2:0]  s_count;
  logic [1:0]  s_ovf;

  logic [15:0] tb_ts;
  logic [63:0] sb[$];
  logic [63:0] sq[$];
  int          tests = 0;
  int          fails = 0;
  int          exp_ovf = 0;
  int          exp_sovf = 0;
  logic [15:0] ts_a, ts_b;

  always #5 clk = ~clk;

  event_capture_queue u_dut (
    .clk(clk), .rst(rst), .in(in_v), .rise_en(rise_en), .fall_en(fall_en),
    .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .count(count),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  event_capture_queue #(.NUM_CH(8), .DEPTH(4), .TS_WIDTH(4), .OVF_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .in(s_in), .rise_en(rise_en), .fall_en(fall_en),
    .rd_en(s_rd_en), .dout(s_dout), .empty(s_empty), .full(s_full), .count(s_count),
    .ovf_count(s_ovf), .ovf_clear(s_ovf_clear)
  );

  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a new level on the main instance and predict the entry it produces
  task automatic set_in(input logic [7:0] nv);
    logic [7:0] m;
    m = (nv & ~in_v & rise_en) | (~nv & in_v & fall_en);
    if (m != 8'h00) begin
      if (sb.size() < 32) sb.push_back(64'({tb_ts + 16'd1, m}));
      else if (exp_ovf < 255) exp_ovf++;
    end
    in_v = nv;
  endtask

  task automatic s_set_in(input logic [7:0] nv);
    logic [7:0] m;
    logic [15:0] t;
    m = (nv & ~s_in & rise_en) | (~nv & s_in & fall_en);
    t = tb_ts + 16'd1;
    if (m != 8'h00) begin
      if (sq.size() < 4) sq.push_back(64'({t[3:0], m}));
      else if (exp_sovf < 3) exp_sovf++;
    end
    s_in = nv;
  endtask

  task automatic pop_main(input string tag);
    if (sb.size() == 0) chk({tag, "_sb_underflow"}, 64'(sb.size()), 64'd1);
    else chk(tag, 64'(dout), sb.pop_front());
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pop_small(input string tag);
    if (sq.size() == 0) chk({tag, "_sq_underflow"}, 64'(sq.size()), 64'd1);
    else chk(tag, 64'(s_dout), sq.pop_front());
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_v = 8'h01; s_in = 8'h00; rise_en = 8'hFF; fall_en = 8'h00;
    rd_en = 1'b0; s_rd_en = 1'b0; ovf_clear = 1'b0; s_ovf_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state, level high through reset gives no edge
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_full", 64'(full), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_ovf", 64'(ovf_count), 64'd0);
    chk("t1_dout", 64'(dout), 64'd0);
    repeat (10) tick();
    chk("t1_no_spurious", 64'(empty), 64'd1);
    chk("t1_s_empty", 64'(s_empty), 64'd1);

    // 2: single rise, two-cycle latency, pop
    set_in(8'h09);
    tick();
    chk("t2_latency_empty", 64'(empty), 64'd1);
    tick();
    chk("t2_empty", 64'(empty), 64'd0);
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_dout", 64'(dout), sb[0]);
    pop_main("t2_pop");
    chk("t2_empty_after", 64'(empty), 64'd1);
    chk("t2_count_after", 64'(count), 64'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t2_rd_when_empty", 64'(count), 64'd0);
    // write into empty with rd_en in the same cycle keeps the entry
    set_in(8'h0B);
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t2_wr_empty_rd", 64'(count), 64'd1);
    pop_main("t2_wr_empty_rd_pop");

    // 3: multi-channel mask then falling edge, ts gap
    set_in(8'h00);
    repeat (3) tick();
    fall_en = 8'h20;
    set_in(8'h21);
    repeat (3) tick();
    set_in(8'h01);
    tick(); tick();
    chk("t3_count", 64'(count), 64'd2);
    ts_a = dout[23:8];
    pop_main("t3_first");
    ts_b = dout[23:8];
    pop_main("t3_second");
    chk("t3_ts_gap", 64'(ts_b - ts_a), 64'd3);
    chk("t3_empty", 64'(empty), 64'd1);

    // 4: fill, overflow, drain in order
    fall_en = 8'hFF;
    for (int i = 0; i < 35; i++) begin
      set_in(in_v ^ 8'h02);
      tick();
    end
    tick(); tick();
    chk("t4_full", 64'(full), 64'd1);
    chk("t4_count", 64'(count), 64'd32);
    chk("t4_ovf", 64'(ovf_count), 64'(exp_ovf));
    chk("t4_ovf_const", 64'(ovf_count), 64'd3);
    for (int i = 0; i < 32; i++) pop_main("t4_pop");
    chk("t4_empty", 64'(empty), 64'd1);

    // 5: full queue, write and pop in the same cycle
    for (int i = 0; i < 32; i++) begin
      set_in(in_v ^ 8'h02);
      tick();
    end
    tick(); tick();
    chk("t5_full", 64'(full), 64'd1);
    chk("t5_head", 64'(dout), sb.pop_front());
    set_in(in_v ^ 8'h04);
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t5_count", 64'(count), 64'd32);
    chk("t5_ovf", 64'(ovf_count), 64'd3);
    for (int i = 0; i < 32; i++) pop_main("t5_pop");
    chk("t5_empty", 64'(empty), 64'd1);

    // 5b: saturation and clear priority on narrow instance
    for (int i = 0; i < 9; i++) begin
      s_set_in(s_in ^ 8'h01);
      tick();
    end
    tick();
    chk("t5_s_full", 64'(s_full), 64'd1);
    chk("t5_s_count", 64'(s_count), 64'd4);
    chk("t5_s_ovf_sat", 64'(s_ovf), 64'(exp_sovf));
    chk("t5_s_ovf_3", 64'(s_ovf), 64'd3);
    s_set_in(s_in ^ 8'h01);
    tick();
    s_ovf_clear = 1'b1; tick(); s_ovf_clear = 1'b0;
    exp_sovf = 0;
    chk("t5_s_ovf_clear", 64'(s_ovf), 64'(exp_sovf));

    // 6: timestamp wrap on narrow instance
    for (int i = 0; i < 4; i++) pop_small("t6_s_drain");
    chk("t6_s_empty", 64'(s_empty), 64'd1);
    s_set_in(s_in ^ 8'h01);
    repeat (20) tick();
    s_set_in(s_in ^ 8'h01);
    tick(); tick();
    chk("t6_s_count", 64'(s_count), 64'd2);
    ts_a = 16'(s_dout[11:8]);
    pop_small("t6_s_first");
    ts_b = 16'(s_dout[11:8]);
    pop_small("t6_s_second");
    chk("t6_ts_wrap", 64'((ts_b - ts_a) & 16'h000F), 64'd4);

    // 6b: reset with entries queued
    for (int i = 0; i < 5; i++) begin
      set_in(in_v ^ 8'h10);
      tick();
    end
    tick();
    chk("t6_count_pre", 64'(count), 64'd5);
    chk("t6_ovf_pre", 64'(ovf_count), 64'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    exp_ovf = 0;
    chk("t6_rst_empty", 64'(empty), 64'd1);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_ovf", 64'(ovf_count), 64'(exp_ovf));
    chk("t6_rst_full", 64'(full), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
